// File: rtl/vga_pixel_source.sv
// rtl/vga_pixel_source.sv - framebuffer/colour-bar pixel source with write port and clear engine
module vga_pixel_source #(
    parameter int H_VIDEO     = 640,
    parameter int V_VIDEO     = 480,
    parameter int SCALE_SHIFT = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_active,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        pattern_en,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync,
    output logic        vsync,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [11:0] wr_data,
    input  logic        clr_req,
    input  logic [11:0] clr_colour,
    output logic        clr_busy,
    output logic        clr_done
);

    localparam int FB_W     = H_VIDEO >> SCALE_SHIFT;
    localparam int FB_H     = V_VIDEO >> SCALE_SHIFT;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int BAR_W    = H_VIDEO / 8;
    localparam logic [14:0] LAST_ADDR = 15'(FB_DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state, state_next;
    logic [14:0] clr_cnt, clr_cnt_next;
    logic [11:0] clr_fill, clr_fill_next;
    logic        clr_done_next;

    logic [14:0] rd_addr;
    logic [14:0] wr_addr;
    logic        wr_in_range;
    logic        mem_we;
    logic [14:0] mem_waddr;
    logic [11:0] mem_wdata;
    logic [11:0] rd_data;
    logic [11:0] mem [FB_DEPTH];

    logic [2:0]  bar;
    logic        active_q, pattern_q, hs_q, vs_q;
    logic [2:0]  bar_q;
    logic [11:0] colour;

    assign rd_addr     = 15'(pix_y >> SCALE_SHIFT) * 15'(FB_W) + 15'(pix_x >> SCALE_SHIFT);
    assign wr_addr     = 15'(wr_y) * 15'(FB_W) + 15'(wr_x);
    assign wr_in_range = (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);

    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (pix_x >= 10'(k * BAR_W)) bar = 3'(k);
        end
    end

    always_comb begin
        state_next    = state;
        clr_cnt_next  = clr_cnt;
        clr_fill_next = clr_fill;
        clr_done_next = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = wr_addr;
        mem_wdata     = wr_data;
        wr_ready      = 1'b0;
        clr_busy      = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                mem_we   = wr_valid && wr_in_range;
                if (clr_req) begin
                    state_next    = CLEAR;
                    clr_cnt_next  = '0;
                    clr_fill_next = clr_colour;
                end
            end
            CLEAR: begin
                clr_busy  = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = clr_fill;
                if (clr_cnt == LAST_ADDR) begin
                    state_next    = IDLE;
                    clr_done_next = 1'b1;
                end else begin
                    clr_cnt_next = clr_cnt + 15'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read-before-write: a same-cycle read of the written address sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_data <= mem[rd_addr];
    end

    // Bar colours decode directly from the index bits: r=~b1, g=~b2, b=~b0.
    always_comb begin
        colour = rd_data;
        if (!active_q)      colour = 12'h000;
        else if (pattern_q) colour = {{4{~bar_q[1]}}, {4{~bar_q[2]}}, {4{~bar_q[0]}}};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            clr_fill  <= '0;
            clr_done  <= 1'b0;
            active_q  <= 1'b0;
            pattern_q <= 1'b0;
            bar_q     <= '0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
        end else begin
            state     <= state_next;
            clr_cnt   <= clr_cnt_next;
            clr_fill  <= clr_fill_next;
            clr_done  <= clr_done_next;
            active_q  <= pix_active;
            pattern_q <= pattern_en;
            bar_q     <= bar;
            hs_q      <= hsync_in;
            vs_q      <= vsync_in;
            red       <= colour[11:8];
            green     <= colour[7:4];
            blue      <= colour[3:0];
            hsync     <= hs_q;
            vsync     <= vs_q;
        end
    end

endmodule

// File: doc/vga_pixel_source.md
# vga_pixel_source

Pixel colour source that sits directly upstream of the VGA timing generator's colour outputs. It takes the current pixel coordinate, active-video flag and sync levels from the timing generator. It returns the 12-bit colour for that pixel, read from either a 160x120 framebuffer scaled 4x4 or a built-in colour-bar test pattern. Sync is delayed by the same amount as colour, so all VGA pins stay aligned. A write port and a hardware clear engine let upstream logic draw into the framebuffer while it is being scanned out.

## Interface
- H_VIDEO, 640: active pixels per line
- V_VIDEO, 480: active lines per frame
- SCALE_SHIFT, 2: log2 of the scale factor; FB_W = H_VIDEO>>SCALE_SHIFT (160), FB_H = V_VIDEO>>SCALE_SHIFT (120), FB_DEPTH = FB_W*FB_H (19200)

Ports:
- clk  in  1  pixel clock
- nrst  in  1  reset, asynchronous, active-low; clock clk
- pix_x  in  10  horizontal coordinate within active video (0..H_VIDEO-1)
- pix_y  in  10  vertical coordinate within active video (0..V_VIDEO-1)
- pix_active  in  1  coordinate is inside the visible area
- hsync_in, vsync_in  in  1 each  sync levels from the timing generator
- pattern_en  in  1  1 = colour bars, 0 = framebuffer
- red, green, blue  out  4 each  pixel colour to pins
- hsync, vsync  out  1 each  sync delayed to match colour
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_x  in  8  framebuffer column
- wr_y  in  7  framebuffer row
- wr_data  in  12  colour {r,g,b}, 4 bits each
- clr_req  in  1  start clear (level sampled per cycle)
- clr_colour  in  12  fill colour, captured when a clear starts
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when a clear completes

## Operation
- Read address = (pix_y>>SCALE_SHIFT)*FB_W + (pix_x>>SCALE_SHIFT), 15 bits, computed combinationally from the inputs.
- Framebuffer is a simple dual-port RAM with synchronous read and one write port. When a read and a write hit the same address in the same cycle, the read returns the old data.
- Output mux:
  - pix_active=0 (delayed): colour 0.
  - pattern_en=1 (delayed): colour bars, bar index = pix_x / (H_VIDEO/8), i.e. 80 px per bar. Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black. Each channel is 4'hF or 4'h0.
  - Otherwise: RAM data.
- Write port: a transfer occurs when wr_valid && wr_ready. Coordinates with wr_x>=FB_W or wr_y>=FB_H are accepted but dropped, with no write.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: wr_ready=1, clr_busy=0. clr_req=1 latches clr_colour, sets the counter to 0 and moves to CLEAR.
  - CLEAR: wr_ready=0, clr_busy=1. Each cycle writes the fill colour to the counter address, then counter+1. The cycle writing FB_DEPTH-1 returns to IDLE and asserts clr_done in that same cycle.
  - clr_req while in CLEAR is ignored. A write request arriving in the same cycle as clr_req in IDLE is still accepted, and the clear starts on the next edge.
- Reads continue during a clear, so a partially cleared image is visible. This is allowed.

## Timing
- Latency from inputs to outputs is exactly 2 clk cycles for red/green/blue/hsync/vsync:
  - Edge 1: registers address-side control (active, pattern, bar index, syncs) and the RAM read.
  - Edge 2: registers the output mux.
- Sampled pattern_en follows the same 2-cycle pipeline, so mode switches take effect cleanly per pixel.
- A write accepted at edge k is visible to a read addressed at edge k+1 or later.
- A clear takes FB_DEPTH cycles of clr_busy=1 (19200). clr_done fires on the edge after the last write is issued; clr_busy falls on the same edge.
- Reset values: red/green/blue=0, hsync=0, vsync=0, clr_busy=0, clr_done=0, wr_ready=1, FSM=IDLE, pipeline registers 0.
- Reset during CLEAR aborts immediately. RAM contents are not reset and are left partially cleared.

## Test plan
- Write port pattern: write (10,5)=12'hABC, set pix_x=40..43, pix_y=20, pix_active=1, pattern_en=0 -> red=A, green=B, blue=C exactly 2 cycles later for all four pixels; pixel 44 shows the contents of (11,5).
- Colour bars: pattern_en=1, sweep pix_x 0..639 -> bar changes at x=80,160,…,560. Colour at x=0 is FFF, at x=400 is F00, at x=560 is 000, each delayed 2 cycles.
- Blanking and sync: pix_active=0 with hsync_in toggling -> colour 0; hsync/vsync reproduce the input waveform shifted by exactly 2 cycles.
- Clear: pulse clr_req with clr_colour=12'h0F0, hold wr_valid=1 -> wr_ready=0 and clr_busy=1 for 19200 cycles, clr_done single pulse at the end. No user writes are taken during the clear; the full readback shows 0F0 everywhere.
- Boundary: write wr_x=160 or wr_y=120 -> accepted (wr_ready=1), RAM unchanged. Simultaneous read and write to the same address -> read returns old data, and the next cycle returns new data.
- Reset mid-clear: deassert nrst at cycle 5000 of a clear -> all outputs reach their reset values asynchronously; after release, FSM=IDLE and wr_ready=1.
